audio_sample_fetcher: RTL and testbench
=======================================

# audio_sample_fetcher

Reads packed stereo PCM words from the on-chip sample RAM (32-bit words, 12-bit word address, one-cycle read latency) and streams them to the audio DAC serializer over a valid/ready interface. It sits between the Nios II-loaded sample RAM and the codec output stage. It is the only master on the RAM's read port during playback. Software programs a start address and length, then pulses start.

## Interface
- AW, 12, RAM word-address width
- DW, 32, RAM/sample word width ([31:16] left, [15:0] right)
- FIFO_DEPTH, 8, output buffer depth in words; power of two, ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; honoured only in IDLE
- stop  in  1  one-cycle pulse; aborts playback in any state
- start_addr  in  AW  first word address, sampled on start
- length  in  AW+1  word count, sampled on start; 0 is legal
- loop  in  1  wrap to start_addr at end of buffer (see Configuration)
- ram_address  out  AW  registered read address
- ram_chipselect  out  1  read strobe, registered
- ram_write  out  1  constant 0
- ram_byteenable  out  4  constant 4'hF
- ram_clken  out  1  constant 1
- ram_readdata  in  DW  valid exactly one cycle after ram_chipselect
- sample_data  out  DW  FIFO head word
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer accepts when valid&ready
- busy  out  1  high in FETCH or DRAIN
- done  out  1  one-cycle pulse on normal completion
- underrun_count  out  16  saturating count of cycles with ready=1, valid=0 while busy

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: start with length≠0 latches start_addr/length, clears FIFO, enters FETCH. start with length=0 pulses done next cycle and stays in IDLE.
- FETCH: a read is issued when fifo_count + inflight < FIFO_DEPTH (inflight ∈ {0,1}). Each issue increments the address (mod 2^AW) and decrements remaining. Returned data is written to the FIFO in the following cycle. When remaining reaches 0, the next state is DRAIN. With loop=1, the address reloads start_addr and remaining reloads length instead.
- DRAIN: no reads are issued. When inflight=0 and the FIFO is empty, pulse done and go to IDLE.
- stop (any state): the next state is IDLE. chipselect deasserts, the FIFO is flushed, any in-flight return is discarded, and done is not pulsed. stop takes priority over a simultaneous start.
- Simultaneous FIFO push and pop: count is unchanged. A push is never blocked because the credit check guarantees space.
- underrun_count clears on start and saturates at 16'hFFFF.

## Timing
- Reset values: state IDLE, ram_address 0, ram_chipselect 0, sample_valid 0, busy 0, done 0, underrun_count 0, FIFO empty.
- start at edge N → first chipselect high during cycle N+1 → data in FIFO at edge N+3 → sample_valid high in cycle N+3.
- Sustained throughput: 1 word/cycle while ready=1.
- busy rises the cycle after start. busy falls in the same cycle done pulses.
- Reset asserted mid-transfer clears everything immediately. No read is issued until the next start.

## Configuration
- AUDIO_FETCH_LOOP_EN defined: the loop input is honoured as described in Operation.
- AUDIO_FETCH_LOOP_EN undefined: loop is ignored, and playback always ends through DRAIN/done.

## Structure
- Package audio_fetch_pkg holds:
  - the state enum (IDLE/FETCH/DRAIN);
  - the default widths (AW, DW);
  - the UNDERRUN_MAX constant.
- Sub-module sample_fifo implements the synchronous FIFO (DW × FIFO_DEPTH, count output, flush input). The fetcher holds the FSM, address/remaining counters, inflight flag and underrun counter.

## Test plan
- start_addr=0x010, length=4, ready=1, RAM preloaded with 0x11110000+i → addresses 0x010–0x013 read once each; four words are output in order; done pulses once; busy=0 afterwards.
- length=0 start → no chipselect; done pulses at start+1; busy stays 0.
- ready=0 with length=20 → exactly FIFO_DEPTH=8 reads are issued, then chipselect stays low. Releasing ready completes all 20 words with none lost or duplicated.
- stop asserted 3 cycles after start, with length=100 → IDLE next cycle; sample_valid=0; no done pulse. A later start with length=2 outputs only the new words.
- start_addr=0xFFE, length=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- AUDIO_FETCH_LOOP_EN defined, loop=1, length=3 → output repeats words 0,1,2,0,1,2…; done is never pulsed until stop is asserted. Holding ready=1 with the RAM stalled yields a matching underrun_count.

Source files
------------

// File: rtl/audio_fetch_pkg.sv
// Shared types and constants for the audio sample fetcher.
// Optional feature macro: AUDIO_FETCH_LOOP_EN (enables looped playback).
package audio_fetch_pkg;

  localparam int AW_DEF         = 12;
  localparam int DW_DEF         = 32;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Saturating increment used by the underrun counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == UNDERRUN_MAX) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous output FIFO for sample words with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop_s;

  // Next-state computation for pointers, count and storage; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop_s = pop && (count_q != {CW{1'b0}});
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == {CW{1'b0}});

endmodule

// File: rtl/audio_sample_fetcher.sv
// Streams packed stereo PCM words from the sample RAM to the DAC serializer.
// Optional feature macro: AUDIO_FETCH_LOOP_EN -- when defined, the loop input
// makes playback wrap back to the start address instead of draining.
module audio_sample_fetcher
  import audio_fetch_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   length,
  input  logic          loop,
  output logic [AW-1:0] ram_address,
  output logic          ram_chipselect,
  output logic          ram_write,
  output logic [3:0]    ram_byteenable,
  output logic          ram_clken,
  input  logic [DW-1:0] ram_readdata,
  output logic [DW-1:0] sample_data,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          busy,
  output logic          done,
  output logic [15:0]   underrun_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic          cs_q, cs_d;        // read strobe presented to the RAM this cycle
  logic          ret_q, ret_d;      // RAM data returning this cycle
  logic [AW-1:0] ram_address_q, ram_address_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [15:0]   underrun_q, underrun_d;

  logic [CW-1:0] fifo_count_s;
  logic          fifo_empty_s;
  logic [DW-1:0] fifo_head_s;
  logic          flush_s;
  logic          pop_s;
  logic          sample_valid_s;
  logic [CW:0]   outstanding_s;
  logic          credit_ok_s;
  logic          loop_en_s;

`ifdef AUDIO_FETCH_LOOP_EN
  assign loop_en_s = loop;
`else
  logic unused_loop_s;
  assign unused_loop_s = loop;
  assign loop_en_s     = 1'b0;
`endif

  assign sample_valid_s = !fifo_empty_s;
  assign pop_s          = sample_valid_s && sample_ready;

  // Words already buffered plus reads still in the pipeline must fit the FIFO,
  // so a returning word can always be pushed.
  assign outstanding_s = {1'b0, fifo_count_s} + (CW+1)'(cs_q) + (CW+1)'(ret_q);
  assign credit_ok_s   = (outstanding_s < (CW+1)'(FIFO_DEPTH));

  sample_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_s),
    .push      (ret_q),
    .push_data (ram_readdata),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  // FSM next state, read issue, counters and status; stop overrides everything.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    base_d        = base_q;
    len_d         = len_q;
    cs_d          = 1'b0;
    ret_d         = cs_q;
    ram_address_d = ram_address_q;
    done_d        = 1'b0;
    flush_s       = 1'b0;
    if (busy_q && sample_ready && !sample_valid_s) begin
      underrun_d = sat_inc16(underrun_q);
    end else begin
      underrun_d = underrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          underrun_d = 16'h0000;
          if (length != {(AW+1){1'b0}}) begin
            base_d      = start_addr;
            len_d       = length;
            addr_d      = start_addr;
            remaining_d = length;
            flush_s     = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (credit_ok_s) begin
          cs_d          = 1'b1;
          ram_address_d = addr_q;
          if (remaining_q == (AW+1)'(1)) begin
            if (loop_en_s) begin
              addr_d      = base_q;
              remaining_d = len_q;
            end else begin
              addr_d      = addr_q + AW'(1);
              remaining_d = {(AW+1){1'b0}};
              state_d     = ST_DRAIN;
            end
          end else begin
            addr_d      = addr_q + AW'(1);
            remaining_d = remaining_q - (AW+1)'(1);
          end
        end else begin
          cs_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!cs_q && !ret_q && fifo_empty_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop) begin
      state_d = ST_IDLE;
      cs_d    = 1'b0;
      ret_d   = 1'b0;
      flush_s = 1'b1;
      done_d  = 1'b0;
    end else begin
      flush_s = flush_s;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= {AW{1'b0}};
      remaining_q   <= {(AW+1){1'b0}};
      base_q        <= {AW{1'b0}};
      len_q         <= {(AW+1){1'b0}};
      cs_q          <= 1'b0;
      ret_q         <= 1'b0;
      ram_address_q <= {AW{1'b0}};
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      underrun_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      base_q        <= base_d;
      len_q         <= len_d;
      cs_q          <= cs_d;
      ret_q         <= ret_d;
      ram_address_q <= ram_address_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      underrun_q    <= underrun_d;
    end
  end

  assign ram_address    = ram_address_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign sample_data    = fifo_head_s;
  assign sample_valid   = sample_valid_s;
  assign busy           = busy_q;
  assign done           = done_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Scoreboard bench for audio_sample_fetcher: a RAM model, a reference model
// that expands each start into the expected address/word streams, and a
// monitor that pops and compares whenever the DUT reads or outputs.
module tb_audio_sample_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, loop;
  logic [11:0] start_addr;
  logic [12:0] length;
  logic [11:0] ram_address;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_readdata;
  logic [31:0] sample_data;
  logic        sample_valid, sample_ready;
  logic        busy, done;
  logic [15:0] underrun_count;

  logic [31:0] mem [4096];
  logic [31:0] exp_data_q [$];
  logic [11:0] exp_addr_q [$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          rd_count = 0;
  int          n_pop = 0;
  int          obs_under = 0;
  int          ready_mode = 1;
  logic        rd_cs = 1'b0;
  logic [11:0] rd_addr = 12'h000;

  always #5 clk = ~clk;

  audio_sample_fetcher dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .start_addr     (start_addr),
    .length         (length),
    .loop           (loop),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .busy           (busy),
    .done           (done),
    .underrun_count (underrun_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a start of n words at a yields reads a, a+1, ... (mod 4096)
  // and the RAM contents at those addresses in order.
  task automatic start_xfer(input logic [11:0] a, input logic [12:0] n);
    logic [11:0] ad;
    for (int i = 0; i < int'(n); i++) begin
      ad = a + 12'(i);
      exp_addr_q.push_back(ad);
      exp_data_q.push_back(mem[ad]);
    end
    start_addr = a;
    length     = n;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int seen;
    d0   = done_cnt;
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
    end
    check("done_within_budget", 32'(seen), 32'd1);
  endtask

  // RAM model: one-cycle read latency; garbage when no read was presented.
  always @(posedge clk) begin
    ram_readdata <= rd_cs ? mem[rd_addr] : 32'hDEADBEEF;
  end

  // Ready driver: 0 = hold low, 1 = hold high, 2 = random per cycle.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      default: sample_ready = 1'($urandom_range(1, 0));
    endcase
  end

  // Monitor: checks read addresses and output words, counts done and underruns.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_chipselect) begin
        rd_count++;
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: address 0x%03h with no read expected", ram_address);
        end else begin
          check("read_addr", 32'(ram_address), 32'(exp_addr_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      if (sample_valid && sample_ready) begin
        n_pop++;
        if (exp_data_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%08h with none expected", sample_data);
        end else begin
          check("sample_data", sample_data, exp_data_q.pop_front());
        end
      end
      if (start && !busy) obs_under = 0;
      else if (busy && sample_ready && !sample_valid) obs_under++;
    end
    rd_cs   = ram_chipselect;
    rd_addr = ram_address;
  end

  initial begin
    int d0, r0, p0;
    logic [11:0] a;
    logic [12:0] n;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'h11110000 + 32'(i);
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    start_addr = 12'h000; length = 13'h0000; sample_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state and constant RAM controls.
    check("rst_cs", 32'(ram_chipselect), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun_count), 32'd0);
    check("ram_write", 32'(ram_write), 32'd0);
    check("ram_be", 32'(ram_byteenable), 32'hF);
    check("ram_clken", 32'(ram_clken), 32'd1);

    // Basic 4-word transfer with latency profile.
    ready_mode = 1;
    d0 = done_cnt;
    start_xfer(12'h010, 13'd4);
    check("t1_busy_rise", 32'(busy), 32'd1);
    check("t1_cs_n0", 32'(ram_chipselect), 32'd0);
    tick(1);
    check("t1_cs_n1", 32'(ram_chipselect), 32'd1);
    check("t1_addr_n1", 32'(ram_address), 32'h010);
    tick(1);
    check("t1_valid_n2", 32'(sample_valid), 32'd0);
    tick(1);
    check("t1_valid_n3", 32'(sample_valid), 32'd1);
    check("t1_data_n3", sample_data, 32'h11110000);
    wait_done(50);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    tick(3);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_words_left", 32'(exp_data_q.size()), 32'd0);
    // Ready was high the whole time: three latency cycles plus the drain cycle.
    check("t1_underrun", 32'(underrun_count), 32'd4);

    // Zero-length start: done next cycle, no reads, underrun cleared.
    r0 = rd_count;
    d0 = done_cnt;
    start_xfer(12'h123, 13'd0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_underrun_clr", 32'(underrun_count), 32'd0);
    tick(1);
    check("t2_done_pulse", 32'(done), 32'd0);
    tick(3);
    check("t2_no_reads", 32'(rd_count - r0), 32'd0);
    check("t2_one_done", 32'(done_cnt - d0), 32'd1);

    // Back-pressure: only FIFO_DEPTH reads until ready is released.
    ready_mode = 0;
    tick(1);
    r0 = rd_count;
    start_xfer(12'(32'h200 + $urandom_range(255, 0)), 13'd20);
    tick(40);
    check("t3_reads_capped", 32'(rd_count - r0), 32'd8);
    check("t3_cs_low", 32'(ram_chipselect), 32'd0);
    check("t3_valid", 32'(sample_valid), 32'd1);
    ready_mode = 1;
    wait_done(200);
    check("t3_total_reads", 32'(rd_count - r0), 32'd20);
    check("t3_words_left", 32'(exp_data_q.size()), 32'd0);

    // Stop mid-transfer: idle next cycle, buffer flushed, no done.
    ready_mode = 0;
    tick(1);
    d0 = done_cnt;
    start_xfer(12'h300, 13'd100);
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(sample_valid), 32'd0);
    check("t4_cs", 32'(ram_chipselect), 32'd0);
    exp_data_q.delete();
    exp_addr_q.delete();
    tick(10);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_still_empty", 32'(sample_valid), 32'd0);
    ready_mode = 1;
    start_xfer(12'h500, 13'd2);
    wait_done(50);
    check("t4_words_left", 32'(exp_data_q.size()), 32'd0);

    // Address wrap at the top of RAM.
    start_xfer(12'hFFE, 13'd4);
    wait_done(50);
    check("t5_addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("t5_words_left", 32'(exp_data_q.size()), 32'd0);

    // Random transfers with random back-pressure; underrun vs observed cycles.
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      a = 12'($urandom);
      n = 13'($urandom_range(30, 1));
      start_xfer(a, n);
      wait_done(600);
      check("rnd_words_left", 32'(exp_data_q.size()), 32'd0);
      check("rnd_underrun", 32'(underrun_count), 32'(obs_under));
      tick(2);
    end

`ifdef AUDIO_FETCH_LOOP_EN
    // Looped playback repeats the buffer until stopped, never pulsing done.
    ready_mode = 1;
    loop = 1'b1;
    d0 = done_cnt;
    p0 = n_pop;
    a = 12'h040;
    for (int i = 3; i < 40; i++) begin
      exp_addr_q.push_back(a + 12'(i % 3));
    end
    start_xfer(a, 13'd3);
    for (int i = 3; i < 40; i++) begin
      exp_data_q.push_back(mem[a + 12'(i % 3)]);
    end
    tick(20);
    check("loop_no_done", 32'(done_cnt - d0), 32'd0);
    check("loop_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    loop = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    check("loop_repeats", 32'((n_pop - p0) >= 9), 32'd1);
    tick(5);
    check("loop_stop_no_done", 32'(done_cnt - d0), 32'd0);
`else
    p0 = n_pop;
`endif

    tick(3);
    check("end_addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
